instr_decoder_pipe: RTL and testbench
=====================================

# instr_decoder_pipe

Parametrised, pipelined successor to the block-instruction decoder. Field widths come from parameters, and all decoded fields leave the block from one aligned output register. It uses valid/ready handshakes on both sides and adds three checks: illegal-opcode detection, read-after-write hazard flagging against the previously emitted instruction, and synchronous flush. It sits between the block instruction memory fetch and the block's operand-fetch/ALU stage.

## Interface
- `DATA_WIDTH`, 16, datapath width; passed through for package consistency and not used internally.
- `INSTR_WIDTH`, 32, instruction word width.
- `OP_WIDTH`, 5, opcode width.
- `REG_ADDR_WIDTH`, 4, register address width.
- `SHIFT_WIDTH`, 5, shift field width.
- `RES_ADDR_WIDTH`, 8, resource address width.
- `NUM_OPS`, 24, opcodes `>= NUM_OPS` are illegal.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline clear.
- `in_instr` in INSTR_WIDTH: instruction word.
- `in_valid` / `in_ready` in/out 1: input handshake.
- `out_valid` / `out_ready` out/in 1: output handshake.
- `operation` out OP_WIDTH.
- `src_a`, `src_b`, `src_c`, `dest` out REG_ADDR_WIDTH each.
- `src_a_reg`, `src_b_reg`, `src_c_reg` out 1 each: 1 = operand is a register.
- `saturate` out 1.
- `instr_shift` out SHIFT_WIDTH.
- `res_addr` out RES_ADDR_WIDTH.
- `illegal` out 1: opcode `>= NUM_OPS`.
- `raw_hazard` out 1: a register source matches the previous emitted `dest`.

## Operation
- Field layout uses LSB-first packing. `R = REG_ADDR_WIDTH + 1`.
  - `op` occupies bits `[OP_WIDTH-1:0]`.
  - `fmt` is the bit at index `OP_WIDTH`.
  - `{a_reg, a}` is the next R bits, then `{b_reg, b}` the following R bits.
- Format 0 (`fmt=0`) continues with: `{c_reg, c}` (R bits), `dest`, shift, then `saturate`.
- Format 1 (`fmt=1`) continues with: `dest`, then `res_addr`. Fixed outputs: `src_c`/`src_c_reg`=0, shift=0, `saturate`=1. Format 0 drives `res_addr`=0.
- Widths are checked at elaboration. `INSTR_WIDTH` must be at least `OP_WIDTH+1+3R+REG_ADDR_WIDTH+SHIFT_WIDTH+1`, and at least `OP_WIDTH+1+2R+REG_ADDR_WIDTH+RES_ADDR_WIDTH`. Failing either is a fatal error.
- Stage 1 (S1) registers the raw word and its valid bit.
- Stage 2 (S2) registers all decoded fields plus `illegal` and `raw_hazard`. `out_valid` = S2 valid.
- Illegal opcodes are still fully decoded and emitted. `illegal` is informational only.
- Hazard tracking:
  - `last_dest` and `last_dest_v` update when an instruction enters S2.
  - `raw_hazard` = `last_dest_v` AND any of `(src_x_reg && src_x == last_dest)` for x in a, b, c.
  - Every instruction is treated as writing `dest`.
  - `last_dest` persists across bubbles.
- Flush clears the S1 valid, S2 valid and `last_dest_v`. Data registers are not cleared. `in_valid` is ignored in the flush cycle.

## Timing
- S2 advances when `!s2_v || out_ready`. S1 advances when `!s1_v || s2_advance`. `in_ready = !s1_v || s2_advance`, which is combinational.
- Latency is 2 cycles from an accepted input to `out_valid`. Throughput is 1 instruction per cycle with `out_ready` held at 1.
- Backpressure: S2 outputs remain stable while `out_valid && !out_ready`. With S1 and S2 both full and `out_ready`=0, `in_ready`=0.
- Simultaneous accept and emit in the same cycle is allowed with no bubble.
- Reset: asynchronous assert. All valids, `last_dest_v` and all outputs go to 0 immediately, so `in_ready`=1 after reset. Deassertion is synchronous to `clk` and is the integrator's responsibility.
- Flush has priority over all handshakes. `out_valid` is 0 on the cycle after flush.

## Structure
- The `instr_dec_pkg` package holds:
  - default width constants;
  - field-offset localparam functions (`off_src_a`, `off_dest_f0`, …);
  - format enum `FMT_ALU=0`, `FMT_RES=1`;
  - the `NUM_OPS` default.
- The sub-module `instr_field_extract` is purely combinational. It maps word → decoded struct and is instantiated between S1 and S2. The top level holds the handshake, hazard and flush logic.

## Test plan
- Format 0 decode: `0x4927AC83` → op=3, `src_a`=2 reg, `src_b`=5 reg, `src_c`=7 non-reg, dest=9, shift=4, sat=1, res=0, illegal=0. `out_valid` rises 2 cycles after accept.
- Format 1 decode: `0x05A20667` → op=7, `src_a`=9 reg, dest=2, `res_addr`=0x5A, sat=1, shift=0, `src_c`=0.
- Hazard:
  - `0x05A20667` then `0x00000481` (reads reg r2) → second word has `raw_hazard`=1.
  - The same pair with `flush` pulsed between them → `raw_hazard`=0.
  - `src_a` non-reg with the same address → 0.
- Illegal opcode: op=0x1F with other fields as in case 1 → `illegal`=1 and fields decoded identically.
- Backpressure:
  - Stream 4 words with `out_ready`=0 → `in_ready` falls after 2 accepts and S2 holds word 1 stable.
  - Release `out_ready` → words emerge in order at 1 per cycle.
- Asynchronous reset asserted mid-stream between clock edges → `out_valid`/outputs are 0 before the next edge and `in_ready`=1. No stale word is emitted after reset.

Source files
------------

// File: rtl/instr_dec_pkg.sv
// Shared widths, format encoding and field-offset helpers for the pipelined
// block-instruction decoder.
package instr_dec_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 16;
    localparam int unsigned INSTR_WIDTH_DEF    = 32;
    localparam int unsigned OP_WIDTH_DEF       = 5;
    localparam int unsigned REG_ADDR_WIDTH_DEF = 4;
    localparam int unsigned SHIFT_WIDTH_DEF    = 5;
    localparam int unsigned RES_ADDR_WIDTH_DEF = 8;
    localparam int unsigned NUM_OPS_DEF        = 24;

    typedef enum logic {
        FMT_ALU = 1'b0,
        FMT_RES = 1'b1
    } fmt_e;

    // Each operand slot is {is_reg, addr}, i.e. REG_ADDR_WIDTH + 1 bits.
    function automatic int unsigned off_src_a(int unsigned op_w);
        return op_w + 1;
    endfunction

    function automatic int unsigned off_src_b(int unsigned op_w, int unsigned ra_w);
        return off_src_a(op_w) + ra_w + 1;
    endfunction

    function automatic int unsigned off_src_c(int unsigned op_w, int unsigned ra_w);
        return off_src_b(op_w, ra_w) + ra_w + 1;
    endfunction

    function automatic int unsigned off_dest_f0(int unsigned op_w, int unsigned ra_w);
        return off_src_c(op_w, ra_w) + ra_w + 1;
    endfunction

    function automatic int unsigned off_shift(int unsigned op_w, int unsigned ra_w);
        return off_dest_f0(op_w, ra_w) + ra_w;
    endfunction

    function automatic int unsigned off_sat(int unsigned op_w, int unsigned ra_w,
                                            int unsigned sh_w);
        return off_shift(op_w, ra_w) + sh_w;
    endfunction

    function automatic int unsigned off_dest_f1(int unsigned op_w, int unsigned ra_w);
        return off_src_c(op_w, ra_w);
    endfunction

    function automatic int unsigned off_res(int unsigned op_w, int unsigned ra_w);
        return off_dest_f1(op_w, ra_w) + ra_w;
    endfunction

endpackage

// File: rtl/instr_decoder_pipe_if.sv
// Input/output handshake and decoded-field bundle of the instruction decoder.
interface instr_decoder_pipe_if
    import instr_dec_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH    = INSTR_WIDTH_DEF,
    parameter int unsigned OP_WIDTH       = OP_WIDTH_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned SHIFT_WIDTH    = SHIFT_WIDTH_DEF,
    parameter int unsigned RES_ADDR_WIDTH = RES_ADDR_WIDTH_DEF
);
    logic [INSTR_WIDTH-1:0]    in_instr;
    logic                      in_valid;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [OP_WIDTH-1:0]       operation;
    logic [REG_ADDR_WIDTH-1:0] src_a;
    logic [REG_ADDR_WIDTH-1:0] src_b;
    logic [REG_ADDR_WIDTH-1:0] src_c;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      src_a_reg;
    logic                      src_b_reg;
    logic                      src_c_reg;
    logic                      saturate;
    logic [SHIFT_WIDTH-1:0]    instr_shift;
    logic [RES_ADDR_WIDTH-1:0] res_addr;
    logic                      illegal;
    logic                      raw_hazard;

    modport master (
        input  in_instr, in_valid, out_ready,
        output in_ready, out_valid, operation, src_a, src_b, src_c, dest,
               src_a_reg, src_b_reg, src_c_reg, saturate, instr_shift, res_addr,
               illegal, raw_hazard
    );

    modport slave (
        output in_instr, in_valid, out_ready,
        input  in_ready, out_valid, operation, src_a, src_b, src_c, dest,
               src_a_reg, src_b_reg, src_c_reg, saturate, instr_shift, res_addr,
               illegal, raw_hazard
    );

endinterface

// File: rtl/instr_field_extract.sv
// Purely combinational word-to-fields decode for both instruction formats.
module instr_field_extract
    import instr_dec_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH    = INSTR_WIDTH_DEF,
    parameter int unsigned OP_WIDTH       = OP_WIDTH_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned SHIFT_WIDTH    = SHIFT_WIDTH_DEF,
    parameter int unsigned RES_ADDR_WIDTH = RES_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_OPS        = NUM_OPS_DEF
) (
    input  logic [INSTR_WIDTH-1:0]    instr,
    output logic [OP_WIDTH-1:0]       operation,
    output logic [REG_ADDR_WIDTH-1:0] src_a,
    output logic [REG_ADDR_WIDTH-1:0] src_b,
    output logic [REG_ADDR_WIDTH-1:0] src_c,
    output logic [REG_ADDR_WIDTH-1:0] dest,
    output logic                      src_a_reg,
    output logic                      src_b_reg,
    output logic                      src_c_reg,
    output logic                      saturate,
    output logic [SHIFT_WIDTH-1:0]    instr_shift,
    output logic [RES_ADDR_WIDTH-1:0] res_addr,
    output logic                      illegal
);
    localparam int unsigned OffA      = off_src_a(OP_WIDTH);
    localparam int unsigned OffB      = off_src_b(OP_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned OffC      = off_src_c(OP_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned OffDestF0 = off_dest_f0(OP_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned OffShift  = off_shift(OP_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned OffSat    = off_sat(OP_WIDTH, REG_ADDR_WIDTH, SHIFT_WIDTH);
    localparam int unsigned OffDestF1 = off_dest_f1(OP_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned OffRes    = off_res(OP_WIDTH, REG_ADDR_WIDTH);

    fmt_e fmt;
    logic unused_instr;

    assign fmt = fmt_e'(instr[OP_WIDTH]);
    // Spare top bits of the word carry no field.
    assign unused_instr = ^instr;

    always_comb begin
        operation   = instr[OP_WIDTH-1:0];
        src_a       = instr[OffA +: REG_ADDR_WIDTH];
        src_a_reg   = instr[OffA + REG_ADDR_WIDTH];
        src_b       = instr[OffB +: REG_ADDR_WIDTH];
        src_b_reg   = instr[OffB + REG_ADDR_WIDTH];
        src_c       = '0;
        src_c_reg   = 1'b0;
        dest        = '0;
        saturate    = 1'b0;
        instr_shift = '0;
        res_addr    = '0;
        illegal     = 32'(instr[OP_WIDTH-1:0]) >= NUM_OPS;
        unique case (fmt)
            FMT_ALU: begin
                src_c       = instr[OffC +: REG_ADDR_WIDTH];
                src_c_reg   = instr[OffC + REG_ADDR_WIDTH];
                dest        = instr[OffDestF0 +: REG_ADDR_WIDTH];
                instr_shift = instr[OffShift +: SHIFT_WIDTH];
                saturate    = instr[OffSat];
            end
            FMT_RES: begin
                dest     = instr[OffDestF1 +: REG_ADDR_WIDTH];
                res_addr = instr[OffRes +: RES_ADDR_WIDTH];
                saturate = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Two-stage valid/ready instruction decoder: S1 holds the raw word, S2 the
// aligned decoded fields plus illegal-opcode and read-after-write flags.
module instr_decoder_pipe
    import instr_dec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH    = INSTR_WIDTH_DEF,
    parameter int unsigned OP_WIDTH       = OP_WIDTH_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned SHIFT_WIDTH    = SHIFT_WIDTH_DEF,
    parameter int unsigned RES_ADDR_WIDTH = RES_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_OPS        = NUM_OPS_DEF
) (
    input logic                  clk,
    input logic                  reset_n,
    input logic                  flush,
    instr_decoder_pipe_if.master bus
);
    localparam int unsigned F0Bits = off_sat(OP_WIDTH, REG_ADDR_WIDTH, SHIFT_WIDTH) + 1;
    localparam int unsigned F1Bits = off_res(OP_WIDTH, REG_ADDR_WIDTH) + RES_ADDR_WIDTH;

    if (INSTR_WIDTH < F0Bits) begin : g_f0_too_narrow
        $fatal(1, "INSTR_WIDTH too narrow for the ALU format");
    end
    if (INSTR_WIDTH < F1Bits) begin : g_f1_too_narrow
        $fatal(1, "INSTR_WIDTH too narrow for the resource format");
    end
    if (DATA_WIDTH == 0) begin : g_bad_data_width
        $fatal(1, "DATA_WIDTH must be nonzero");
    end

    logic                      s1_v_q, s2_v_q, last_dest_v_q;
    logic [INSTR_WIDTH-1:0]    s1_instr_q;
    logic [REG_ADDR_WIDTH-1:0] last_dest_q;
    logic                      s1_adv, s2_adv, hazard;

    logic [OP_WIDTH-1:0]       dec_op, op_q;
    logic [REG_ADDR_WIDTH-1:0] dec_a, dec_b, dec_c, dec_dest, a_q, b_q, c_q, dest_q;
    logic                      dec_a_reg, dec_b_reg, dec_c_reg, dec_sat, dec_ill;
    logic                      a_reg_q, b_reg_q, c_reg_q, sat_q, ill_q, haz_q;
    logic [SHIFT_WIDTH-1:0]    dec_shift, shift_q;
    logic [RES_ADDR_WIDTH-1:0] dec_res, res_q;

    instr_field_extract #(
        .INSTR_WIDTH   (INSTR_WIDTH),
        .OP_WIDTH      (OP_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .SHIFT_WIDTH   (SHIFT_WIDTH),
        .RES_ADDR_WIDTH(RES_ADDR_WIDTH),
        .NUM_OPS       (NUM_OPS)
    ) u_extract (
        .instr      (s1_instr_q),
        .operation  (dec_op),
        .src_a      (dec_a),
        .src_b      (dec_b),
        .src_c      (dec_c),
        .dest       (dec_dest),
        .src_a_reg  (dec_a_reg),
        .src_b_reg  (dec_b_reg),
        .src_c_reg  (dec_c_reg),
        .saturate   (dec_sat),
        .instr_shift(dec_shift),
        .res_addr   (dec_res),
        .illegal    (dec_ill)
    );

    always_comb begin
        s2_adv = !s2_v_q || bus.out_ready;
        s1_adv = !s1_v_q || s2_adv;
        hazard = last_dest_v_q && ((dec_a_reg && (dec_a == last_dest_q)) ||
                                   (dec_b_reg && (dec_b == last_dest_q)) ||
                                   (dec_c_reg && (dec_c == last_dest_q)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q        <= 1'b0;
            s2_v_q        <= 1'b0;
            last_dest_v_q <= 1'b0;
            last_dest_q   <= '0;
        end else if (flush) begin
            s1_v_q        <= 1'b0;
            s2_v_q        <= 1'b0;
            last_dest_v_q <= 1'b0;
        end else begin
            if (s1_adv) s1_v_q <= bus.in_valid;
            if (s2_adv) s2_v_q <= s1_v_q;
            // Every emitted instruction counts as a writer of its dest.
            if (s2_adv && s1_v_q) begin
                last_dest_q   <= dec_dest;
                last_dest_v_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_instr_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            dest_q  <= '0;
            a_reg_q <= 1'b0;
            b_reg_q <= 1'b0;
            c_reg_q <= 1'b0;
            sat_q   <= 1'b0;
            shift_q <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
            haz_q   <= 1'b0;
        end else begin
            if (!flush && s1_adv && bus.in_valid) s1_instr_q <= bus.in_instr;
            if (!flush && s2_adv && s1_v_q) begin
                op_q    <= dec_op;
                a_q     <= dec_a;
                b_q     <= dec_b;
                c_q     <= dec_c;
                dest_q  <= dec_dest;
                a_reg_q <= dec_a_reg;
                b_reg_q <= dec_b_reg;
                c_reg_q <= dec_c_reg;
                sat_q   <= dec_sat;
                shift_q <= dec_shift;
                res_q   <= dec_res;
                ill_q   <= dec_ill;
                haz_q   <= hazard;
            end
        end
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = s2_v_q;
    assign bus.operation   = op_q;
    assign bus.src_a       = a_q;
    assign bus.src_b       = b_q;
    assign bus.src_c       = c_q;
    assign bus.dest        = dest_q;
    assign bus.src_a_reg   = a_reg_q;
    assign bus.src_b_reg   = b_reg_q;
    assign bus.src_c_reg   = c_reg_q;
    assign bus.saturate    = sat_q;
    assign bus.instr_shift = shift_q;
    assign bus.res_addr    = res_q;
    assign bus.illegal     = ill_q;
    assign bus.raw_hazard  = haz_q;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe: decode table, hazard, flush,
// backpressure and asynchronous reset sequences.
module tb_instr_decoder_pipe;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    instr_decoder_pipe_if bus ();

    instr_decoder_pipe dut (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  op;
        logic [3:0]  a;
        logic        ar;
        logic [3:0]  b;
        logic        br;
        logic [3:0]  c;
        logic        cr;
        logic [3:0]  d;
        logic [4:0]  sh;
        logic        sat;
        logic [7:0]  res;
        logic        ill;
        logic        haz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_fields(input string p, input vec_t v);
        chk({p, ".op"},    32'(bus.operation),   32'(v.op));
        chk({p, ".a"},     32'(bus.src_a),       32'(v.a));
        chk({p, ".a_reg"}, 32'(bus.src_a_reg),   32'(v.ar));
        chk({p, ".b"},     32'(bus.src_b),       32'(v.b));
        chk({p, ".b_reg"}, 32'(bus.src_b_reg),   32'(v.br));
        chk({p, ".c"},     32'(bus.src_c),       32'(v.c));
        chk({p, ".c_reg"}, 32'(bus.src_c_reg),   32'(v.cr));
        chk({p, ".dest"},  32'(bus.dest),        32'(v.d));
        chk({p, ".shift"}, 32'(bus.instr_shift), 32'(v.sh));
        chk({p, ".sat"},   32'(bus.saturate),    32'(v.sat));
        chk({p, ".res"},   32'(bus.res_addr),    32'(v.res));
        chk({p, ".ill"},   32'(bus.illegal),     32'(v.ill));
        chk({p, ".haz"},   32'(bus.raw_hazard),  32'(v.haz));
    endtask

    // Called at a negedge; returns at the negedge where the word sits in S2.
    task automatic send_one(input logic [31:0] w, input string p);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({p, ".valid_lat1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({p, ".valid_lat2"}, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h4927AC83, 5'd3,  4'd2, 1'b1, 4'd5, 1'b1, 4'd7, 1'b0, 4'd9,
                    5'd4, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{32'h05A20667, 5'd7,  4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2,
                    5'd0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[2] = '{32'h00000481, 5'd1,  4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                    5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{32'h4927AC9F, 5'd31, 4'd2, 1'b1, 4'd5, 1'b1, 4'd7, 1'b0, 4'd9,
                    5'd4, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{32'h05A20667, 5'd7,  4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2,
                    5'd0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[5] = '{32'h00000081, 5'd1,  4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                    5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{32'h00000017, 5'd23, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                    5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{32'h00000018, 5'd24, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                    5'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{32'h00100000, 5'd0,  4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0,
                    5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{32'h00008000, 5'd0,  4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0,
                    5'd0, 1'b0, 8'h00, 1'b0, 1'b1};

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst.op",        32'(bus.operation), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].instr, $sformatf("v%0d", i));
            check_fields($sformatf("v%0d", i), vecs[i]);
        end

        // Flush between writer and reader kills the hazard.
        send_one(32'h05A20667, "fl_w");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl.out_valid_after", 32'(bus.out_valid), 32'd0);
        send_one(32'h00000481, "fl_r");
        chk("fl.haz", 32'(bus.raw_hazard), 32'd0);
        chk("fl.a",   32'(bus.src_a),      32'd2);

        // Flush with a word in S1 (and in_valid held) emits nothing.
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00000002;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2.out_valid0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("fl2.out_valid1", 32'(bus.out_valid), 32'd0);

        // Backpressure: two words fill the pipe, the third stalls.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00000001;
        chk("bp.ready0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp.ready1", 32'(bus.in_ready), 32'd1);
        bus.in_instr = 32'h00000002;
        @(negedge clk);
        bus.in_instr = 32'h00000003;
        chk("bp.ready2",  32'(bus.in_ready),  32'd0);
        chk("bp.valid2",  32'(bus.out_valid), 32'd1);
        chk("bp.op2",     32'(bus.operation), 32'd1);
        @(negedge clk);
        chk("bp.ready3",  32'(bus.in_ready),  32'd0);
        chk("bp.op3",     32'(bus.operation), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.ready_rel", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp.op_w2", 32'(bus.operation), 32'd2);
        bus.in_instr = 32'h00000004;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp.op_w3", 32'(bus.operation), 32'd3);
        @(negedge clk);
        chk("bp.op_w4",    32'(bus.operation), 32'd4);
        chk("bp.valid_w4", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk("bp.drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset between edges with the pipe full.
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00000005;
        @(negedge clk);
        bus.in_instr = 32'h00000006;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ar.pre_op", 32'(bus.operation), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar.op",        32'(bus.operation), 32'd0);
        chk("ar.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ar.post0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("ar.post1", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
